// File: rtl/skip_sequencer.sv
// Squash sequencer for the ez8 conditional-skip instructions (1010/1011/1100).
// Optional skip statistics counter is built only when SKIP_STATS_EN is defined.
module skip_sequencer #(
  parameter logic [15:0] SAT_MAX = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [3:0]  ex_opcode,
  input  logic        skip,
  input  logic        stall,
  input  logic        flush,
  input  logic        stats_clr,
  output logic        kill,
  output logic        irq_block,
  output logic        skip_taken,
  output logic [15:0] skip_count
);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t state_reg;
  logic   skip_taken_reg;
  logic   is_skip_op;
  logic   arm;

  // Opcode is decoded here so a stray skip=1 on other opcodes can never arm.
  assign is_skip_op = (ex_opcode == 4'b1010) || (ex_opcode == 4'b1011) ||
                      (ex_opcode == 4'b1100);

  assign arm = (state_reg == IDLE) && ex_valid && !stall && !flush &&
               is_skip_op && skip;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      skip_taken_reg <= 1'b0;
    end else begin
      skip_taken_reg <= arm;
      case (state_reg)
        IDLE: begin
          if (arm) state_reg <= PENDING;
        end
        PENDING: begin
          // A skip instruction squashed here never re-arms: no chaining.
          if (flush || (ex_valid && !stall)) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign kill       = (state_reg == PENDING);
  assign irq_block  = (state_reg == PENDING);
  assign skip_taken = skip_taken_reg;

`ifdef SKIP_STATS_EN
  logic [15:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || stats_clr) begin
      count_reg <= 16'd0;
    end else if (arm && (count_reg != SAT_MAX)) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  assign skip_count = count_reg;
`else
  logic unused_stats;
  assign unused_stats = ^{stats_clr, SAT_MAX};
  assign skip_count   = 16'd0;
`endif

endmodule

// File: tb/tb_skip_sequencer.sv
// Directed self-checking bench for skip_sequencer; counter checks adapt to SKIP_STATS_EN.
module tb_skip_sequencer;

`ifdef SKIP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic        skip;
  logic        stall;
  logic        flush;
  logic        stats_clr;
  logic        kill;
  logic        irq_block;
  logic        skip_taken;
  logic [15:0] skip_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  skip_sequencer #(.SAT_MAX(16'h0003)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .skip(skip), .stall(stall), .flush(flush), .stats_clr(stats_clr),
    .kill(kill), .irq_block(irq_block), .skip_taken(skip_taken),
    .skip_count(skip_count)
  );

  // Advance one cycle; outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; ex_valid = 0; ex_opcode = 4'b0000; skip = 0;
    stall = 0; flush = 0; stats_clr = 0;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic s,
                       input logic st, input logic fl);
    ex_valid = v; ex_opcode = op; skip = s; stall = st; flush = fl;
  endtask

  function automatic logic [15:0] count_exp();
    return STATS ? 16'(exp_count) : 16'd0;
  endfunction

  function automatic void bump_count();
    if (exp_count < 3) exp_count++;
  endfunction

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
    exp_count = 0;
    checks++;
    if (kill !== 1'b0 || irq_block !== 1'b0 || skip_taken !== 1'b0 || skip_count !== 16'd0) begin
      errors++;
      $display("FAIL reset: kill=%b irq_block=%b skip_taken=%b count=%0d, want 0/0/0/0",
               kill, irq_block, skip_taken, skip_count);
    end
    $display("reset: kill=%b irq_block=%b skip_taken=%b count=%0d", kill, irq_block, skip_taken, skip_count);
  endtask

  task automatic test_basic();
    drive(1, 4'b1010, 1, 0, 0);
    checks++;
    if (kill !== 1'b0) begin errors++; $display("FAIL basic_arm_cycle: kill=%b want 0", kill); end
    step();
    bump_count();
    drive(1, 4'b0011, 0, 0, 0);
    checks++;
    if (kill !== 1'b1 || irq_block !== 1'b1 || skip_taken !== 1'b1) begin
      errors++;
      $display("FAIL basic_squash: kill=%b irq_block=%b skip_taken=%b want 1/1/1", kill, irq_block, skip_taken);
    end
    step();
    drive(0, 4'b0000, 0, 0, 0);
    checks++;
    if (kill !== 1'b0 || skip_taken !== 1'b0 || skip_count !== count_exp()) begin
      errors++;
      $display("FAIL basic_release: kill=%b skip_taken=%b count=%0d want 0/0/%0d",
               kill, skip_taken, skip_count, count_exp());
    end
    $display("basic: released kill=%b count=%0d", kill, skip_count);
  endtask

  task automatic test_not_taken();
    int bad = 0;
    drive(1, 4'b1011, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (kill !== 1'b0 || skip_taken !== 1'b0) begin
        errors++; bad++;
        $display("FAIL not_taken_%0d: kill=%b skip_taken=%b want 0/0", i, kill, skip_taken);
      end
    end
    drive(1, 4'b0001, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (kill !== 1'b0 || skip_taken !== 1'b0) begin
        errors++; bad++;
        $display("FAIL non_skip_op_%0d: kill=%b skip_taken=%b want 0/0", i, kill, skip_taken);
      end
    end
    drive(0, 4'b0000, 0, 0, 0);
    $display("not_taken: %0d bad cycles", bad);
  endtask

  task automatic test_stall_bubble();
    logic exp_kill [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    drive(1, 4'b1011, 1, 0, 0);
    step();
    bump_count();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0, 1: drive(0, 4'b0000, 0, 0, 0);
        2: drive(1, 4'b0010, 0, 1, 0);
        3: drive(1, 4'b0010, 0, 0, 0);
        default: drive(0, 4'b0000, 0, 0, 0);
      endcase
      checks++;
      if (kill !== exp_kill[i] || irq_block !== exp_kill[i]) begin
        errors++;
        $display("FAIL stall_bubble_c%0d: kill=%b irq_block=%b want %b", i + 4, kill, irq_block, exp_kill[i]);
      end
      step();
    end
    $display("stall_bubble: end kill=%b", kill);
  endtask

  task automatic test_back_to_back();
    drive(1, 4'b1100, 1, 0, 0);
    step();
    bump_count();
    checks++;
    if (kill !== 1'b1 || skip_taken !== 1'b1) begin
      errors++; $display("FAIL b2b_first: kill=%b skip_taken=%b want 1/1", kill, skip_taken);
    end
    drive(1, 4'b1100, 1, 0, 0);
    step();
    drive(0, 4'b0000, 0, 0, 0);
    checks++;
    if (kill !== 1'b0 || skip_taken !== 1'b0 || skip_count !== count_exp()) begin
      errors++;
      $display("FAIL b2b_second: kill=%b skip_taken=%b count=%0d want 0/0/%0d",
               kill, skip_taken, skip_count, count_exp());
    end
    step();
    checks++;
    if (kill !== 1'b0) begin errors++; $display("FAIL b2b_idle: kill=%b want 0", kill); end
    $display("back_to_back: count=%0d", skip_count);
  endtask

  task automatic test_flush_reset();
    drive(1, 4'b1010, 1, 0, 0);
    step();
    bump_count();
    drive(0, 4'b0000, 0, 0, 1);
    checks++;
    if (kill !== 1'b1) begin errors++; $display("FAIL flush_same_cycle: kill=%b want 1", kill); end
    step();
    drive(0, 4'b0000, 0, 0, 0);
    checks++;
    if (kill !== 1'b0 || irq_block !== 1'b0) begin
      errors++; $display("FAIL flush_next: kill=%b irq_block=%b want 0/0", kill, irq_block);
    end
    // Flush coincident with a would-be arm.
    drive(1, 4'b1011, 1, 0, 1);
    step();
    drive(0, 4'b0000, 0, 0, 0);
    checks++;
    if (kill !== 1'b0 || skip_taken !== 1'b0 || skip_count !== count_exp()) begin
      errors++;
      $display("FAIL flush_arm: kill=%b skip_taken=%b count=%0d want 0/0/%0d",
               kill, skip_taken, skip_count, count_exp());
    end
    drive(1, 4'b1010, 1, 0, 0);
    step();
    bump_count();
    drive(1, 4'b0100, 0, 0, 0);
    reset = 1;
    step();
    reset = 0;
    exp_count = 0;
    drive(0, 4'b0000, 0, 0, 0);
    checks++;
    if (kill !== 1'b0 || irq_block !== 1'b0 || skip_taken !== 1'b0 || skip_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_pending: kill=%b irq_block=%b skip_taken=%b count=%0d want all 0",
               kill, irq_block, skip_taken, skip_count);
    end
    $display("flush_reset: kill=%b count=%0d", kill, skip_count);
  endtask

  task automatic test_skip_stall();
    drive(1, 4'b1011, 1, 1, 0);
    step();
    checks++;
    if (kill !== 1'b0 || skip_taken !== 1'b0) begin
      errors++; $display("FAIL skip_stalled: kill=%b skip_taken=%b want 0/0", kill, skip_taken);
    end
    drive(1, 4'b1011, 0, 0, 0);
    step();
    drive(0, 4'b0000, 0, 0, 0);
    checks++;
    if (kill !== 1'b0) begin errors++; $display("FAIL skip_advance_false: kill=%b want 0", kill); end
    $display("skip_stall: kill=%b", kill);
  endtask

  task automatic test_stats();
    for (int i = 0; i < 5; i++) begin
      drive(1, 4'b1010, 1, 0, 0);
      step();
      bump_count();
      drive(1, 4'b0000, 0, 0, 0);
      step();
      drive(0, 4'b0000, 0, 0, 0);
      checks++;
      if (skip_count !== count_exp()) begin
        errors++; $display("FAIL stats_arm_%0d: count=%0d want %0d", i, skip_count, count_exp());
      end
    end
    drive(1, 4'b1100, 1, 0, 0);
    stats_clr = 1;
    step();
    stats_clr = 0;
    exp_count = 0;
    drive(1, 4'b0000, 0, 0, 0);
    checks++;
    if (skip_count !== 16'd0 || kill !== 1'b1) begin
      errors++; $display("FAIL stats_clr: count=%0d kill=%b want 0/1", skip_count, kill);
    end
    step();
    drive(0, 4'b0000, 0, 0, 0);
    $display("stats: count=%0d", skip_count);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_not_taken();
    test_stall_bubble();
    test_back_to_back();
    test_flush_reset();
    test_skip_stall();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/skip_sequencer.md
# skip_sequencer

Pipeline controller that sequences the conditional-skip instructions (opcodes 4'b1010 skip-on-condition, 4'b1011 skip-if-bit-set, 4'b1100 skip-if-bit-clear) of the ez8 core. It consumes the combinational skip decision for the instruction in the execute stage. When a skip is taken, it squashes the next valid instruction to reach execute, tolerating stalls, bubbles and control-transfer flushes. It also blocks interrupt entry while a squash is pending, so the skipped instruction is never resumed after a return.

## Interface
- SAT_MAX, 16'hFFFF, saturation value of the skip counter (only used with SKIP_STATS_EN)
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  execute-stage slot holds a real instruction (not a bubble)
- ex_opcode  in  4  opcode of the execute-stage instruction
- skip  in  1  skip-condition result for the execute-stage instruction (from the skip-condition evaluator)
- stall  in  1  pipeline hold; no stage advances this cycle
- flush  in  1  control transfer (jump/call/return/interrupt entry) taken this cycle; younger instructions discarded elsewhere
- stats_clr  in  1  synchronous clear of skip_count
- kill  out  1  execute-stage instruction must not commit (no register, memory, PC-redirect or flag side effects)
- irq_block  out  1  interrupt controller must not take an interrupt this cycle
- skip_taken  out  1  one-cycle pulse, cycle after a skip is armed
- skip_count  out  16  number of skips taken, saturating

## Operation
- States:
  - IDLE: no squash pending.
  - PENDING: the next valid execute-stage instruction is to be squashed.
- Skip instruction: ex_opcode ∈ {4'b1010, 4'b1011, 4'b1100}. The opcode check is made locally, independent of skip being 0 for other opcodes.
- arm = state==IDLE && ex_valid && !stall && !flush && skip instruction && skip.
- IDLE → PENDING on arm; otherwise stay IDLE.
- PENDING → IDLE:
  - on ex_valid && !stall (the squashed instruction leaves execute); or
  - on flush.
- PENDING stays PENDING on a bubble (ex_valid=0) or a stall.
- A skip instruction arriving in execute while PENDING is itself squashed:
  - it does not arm;
  - the FSM returns to IDLE (no chained skip).
- Outputs (Moore, decoded from state):
  - kill = (state==PENDING).
  - irq_block = (state==PENDING).
- skip_taken: register loaded with arm every cycle.
- Priority: reset > flush > arm.

## Timing
- Reset values:
  - state=IDLE
  - kill=0
  - irq_block=0
  - skip_taken=0
  - skip_count=0
- Arm in cycle N → kill=1 and skip_taken=1 in cycle N+1.
- kill holds through stalls and bubbles until the first cycle with ex_valid=1 && stall=0. kill is 1 in that cycle and 0 the next.
- Minimum squash window: exactly one cycle (next instruction immediately behind, no stall).
- flush in a PENDING cycle: kill still 1 that cycle; IDLE next cycle.
- flush together with a would-be arm: no arm, state stays IDLE, no skip_taken, no count.
- reset in PENDING: IDLE next cycle; kill/irq_block drop next cycle.
- skip with stall=1: no arm. Arm is evaluated again on the cycle the instruction advances, using skip in that cycle.
- Back-to-back skip instructions: the first arms, the second is killed. After the second leaves, the FSM is IDLE with no new squash.

## Configuration
- SKIP_STATS_EN defined:
  - skip_count increments by 1 on each arm, saturating at SAT_MAX.
  - stats_clr loads 0 and wins over a same-cycle increment.
  - The count is visible the cycle after the arm.
- SKIP_STATS_EN undefined:
  - No counter register is built.
  - skip_count is tied to 16'd0.
  - stats_clr is ignored.
  - SAT_MAX is unused.

## Test plan
- Basic taken skip: opcode 1010, skip=1, ex_valid=1, stall=0 at cycle 5 → kill=1, irq_block=1, skip_taken=1 at cycle 6. Next instruction valid at cycle 6 → kill=0 at cycle 7; skip_count=1 (stats build).
- Not taken: opcode 1011, skip=0 → kill stays 0 and skip_taken stays 0 for 10 cycles. Non-skip opcode 4'b0001 with skip forced 1 → no arm.
- Stall/bubble hold: arm at cycle 3; ex_valid=0 at cycles 4–5, stall=1 at cycle 6, valid advance at cycle 7 → kill=1 for cycles 4–7, 0 at cycle 8.
- Back-to-back skips: opcode 1100/skip=1 at cycles 2 and 3 → kill=1 only at cycle 3, IDLE at cycle 4; skip_count=1.
- Flush/reset: arm at cycle 2, flush=1 at cycle 3 → kill=1 at cycle 3, 0 at cycle 4. Repeat with reset=1 at cycle 3 → all outputs 0 at cycle 4. flush coincident with an arm → no skip_taken.
- Stats (SKIP_STATS_EN, SAT_MAX=16'h0003): 5 taken skips → skip_count=3. stats_clr together with a 6th arm → skip_count=0.
